// File: rtl/tl_cntr.sv
// Two-road traffic-light controller: Moore FSM plus an 8-bit dwell counter.
// Define TL_ALLRED_EN to add all-red clearance states RA/RB after each yellow.
`timescale 1ns/1ps
module tl_cntr #(
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 8,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    GA = 3'b000,
    YA = 3'b001,
    GB = 3'b010,
    YB = 3'b011,
    RA = 3'b100,
    RB = 3'b101
  } state_e;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  localparam logic [7:0] GMIN_LAST = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_LAST  = 8'(YELLOW_CYC - 1);
`ifdef TL_ALLRED_EN
  localparam logic [7:0] AR_LAST   = 8'(ALLRED_CYC - 1);
`endif

  if (GREEN_MIN < 1 || GREEN_MIN > GREEN_MAX || GREEN_MAX > 255 ||
      YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_bad_params
    $error("tl_cntr: illegal parameter combination");
  end

  // state_q is a plain vector so that unused codes are representable.
  logic [2:0] state_q;
  state_e     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       is_green;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = GA;
    case (state_q)
      GA: state_d = (cnt_q >= GMIN_LAST && (!Ta || (Tb && cnt_q == GMAX_LAST))) ? YA : GA;
      GB: state_d = (cnt_q >= GMIN_LAST && (!Tb || (Ta && cnt_q == GMAX_LAST))) ? YB : GB;
`ifdef TL_ALLRED_EN
      YA: state_d = (cnt_q == YEL_LAST) ? RA : YA;
      YB: state_d = (cnt_q == YEL_LAST) ? RB : YB;
      RA: state_d = (cnt_q == AR_LAST) ? GB : RA;
      RB: state_d = (cnt_q == AR_LAST) ? GA : RB;
`else
      YA: state_d = (cnt_q == YEL_LAST) ? GB : YA;
      YB: state_d = (cnt_q == YEL_LAST) ? GA : YB;
`endif
      default: state_d = GA;
    endcase
  end

  // Saturation only matters in green; other states leave before overflow.
  always_comb begin
    is_green = (state_q == GA) || (state_q == GB);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (is_green && cnt_q == GMAX_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    La = L_RED;
    Lb = L_RED;
    case (state_q)
      GA: La = L_GREEN;
      YA: La = L_YELLOW;
      GB: Lb = L_GREEN;
      YB: Lb = L_YELLOW;
      default: begin
        La = L_RED;
        Lb = L_RED;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_tl_cntr.sv
// Self-checking bench for tl_cntr: randomized sensors against a phase-level model.
// Honours TL_ALLRED_EN when the bench is compiled with it.
`timescale 1ns/1ps
module tb_tl_cntr;

  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic [1:0] la;
  logic [1:0] lb;
  logic [2:0] st;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];
  logic [2:0] trace[$];

  // Model: road with right of way (0=A,1=B), phase (0 green,1 yellow,2 all-red), cycles spent.
  int m_g;
  int m_ph;
  int m_el;

  tl_cntr dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Ta      (ta),
    .Tb      (tb),
    .La      (la),
    .Lb      (lb),
    .state   (st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_exp();
    logic [2:0] code;
    logic [1:0] act_l;
    logic [1:0] el_a;
    logic [1:0] el_b;
    code  = (m_ph == 2) ? 3'(4 + m_g) : 3'(m_g * 2 + m_ph);
    act_l = (m_ph == 0) ? 2'b00 : (m_ph == 1) ? 2'b01 : 2'b10;
    el_a  = (m_g == 0) ? act_l : 2'b10;
    el_b  = (m_g == 1) ? act_l : 2'b10;
    return {1'b0, code, el_a, el_b};
  endfunction

  task automatic model_reset(input bit push_now);
    m_g  = 0;
    m_ph = 0;
    m_el = 0;
    exp_q.delete();
    if (push_now) exp_q.push_back(model_exp());
  endtask

  task automatic model_step();
    bit mine;
    bit other;
    mine  = (m_g == 0) ? ta : tb;
    other = (m_g == 0) ? tb : ta;
    case (m_ph)
      0: begin
        if (m_el >= GMIN - 1 && (!mine || (other && m_el >= GMAX - 1))) begin
          m_ph = 1;
          m_el = 0;
        end else m_el++;
      end
      1: begin
        if (m_el >= YEL - 1) begin
`ifdef TL_ALLRED_EN
          m_ph = 2;
`else
          m_g  = 1 - m_g;
          m_ph = 0;
`endif
          m_el = 0;
        end else m_el++;
      end
      default: begin
        if (m_el >= AR - 1) begin
          m_g  = 1 - m_g;
          m_ph = 0;
          m_el = 0;
        end else m_el++;
      end
    endcase
    exp_q.push_back(model_exp());
  endtask

  task automatic compare(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 8'd1, 8'd0);
    end else begin
      check(tag, {1'b0, st, la, lb}, exp_q.pop_front());
    end
    trace.push_back(st);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2 check("reset_state", {1'b0, st, la, lb}, {1'b0, 3'b000, 2'b00, 2'b10});
    @(negedge clk);
    reset_n = 1'b1;
    model_reset(1'b1);
  endtask

  // Called at a falling edge once that cycle has been compared.
  task automatic reset_pulse(input string tag);
    #1 reset_n = 1'b0;
    #1 check({tag, "_low"}, {1'b0, st, la, lb}, {1'b0, 3'b000, 2'b00, 2'b10});
    #2 reset_n = 1'b1;
    #0.3 check({tag, "_rel"}, {1'b0, st, la, lb}, {1'b0, 3'b000, 2'b00, 2'b10});
    model_reset(1'b0);
  endtask

  initial begin
    int run_code[$];
    int run_len[$];
    bit found;

    // Lone road B waiting: A green 4, yellow 2, then B (or all-red first).
    hard_reset();
    ta = 1'b0;
    tb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      compare("ta0_tb1");
      if (c == 3) check("c3_la_green", {6'd0, la}, 8'h00);
      if (c == 4) check("c4_la_yellow", {6'd0, la}, 8'h01);
`ifdef TL_ALLRED_EN
      if (c == 6) check("c6_allred", {1'b0, st, la, lb}, {1'b0, 3'b100, 2'b10, 2'b10});
      if (c == 7) check("c7_lb_green", {6'd0, lb}, 8'h00);
`else
      if (c == 6) check("c6_lb_green", {6'd0, lb}, 8'h00);
`endif
      advance();
    end

    // Road A busy, B empty: A keeps green.
    hard_reset();
    ta = 1'b1;
    tb = 1'b0;
    for (int c = 0; c < 50; c++) begin
      compare("ta1_tb0");
      check("ga_hold", {1'b0, st, la, lb}, {1'b0, 3'b000, 2'b00, 2'b10});
      advance();
    end

    // Both busy: greens cut at the maximum.
    hard_reset();
    ta = 1'b1;
    tb = 1'b1;
    trace.delete();
    for (int c = 0; c < 42; c++) begin
      compare("both_busy");
      advance();
    end
    foreach (trace[i]) begin
      if (run_code.size() != 0 && run_code[run_code.size() - 1] == int'(trace[i]))
        run_len[run_len.size() - 1]++;
      else begin
        run_code.push_back(int'(trace[i]));
        run_len.push_back(1);
      end
    end
    check("run_count", 8'(run_len.size() >= 5), 8'd1);
    for (int r = 0; r < run_len.size() - 1; r++) begin
      case (run_code[r])
        0, 2:    check("green_len", 8'(run_len[r]), 8'(GMAX));
        1, 3:    check("yellow_len", 8'(run_len[r]), 8'(YEL));
        default: check("allred_len", 8'(run_len[r]), 8'(AR));
      endcase
    end

    // Asynchronous reset pulse in the middle of YB.
    hard_reset();
    ta = 1'b0;
    tb = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      compare("idle_alt");
      if (m_g == 1 && m_ph == 1) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    check("reach_yb", 8'(found), 8'd1);
    reset_pulse("yb_reset");
    advance();
    for (int c = 0; c < 12; c++) begin
      compare("after_yb_reset");
      advance();
    end

    // Randomized sensors with occasional asynchronous resets.
    hard_reset();
    for (int c = 0; c < 800; c++) begin
      compare("random");
      if ($urandom_range(0, 3) == 0) ta = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) reset_pulse("rand_reset");
      advance();
    end

    // Illegal state code recovers to GA.
    force dut.state_q = 3'b111;
    #1 check("forced_111", {1'b0, st, la, lb}, {1'b0, 3'b111, 2'b10, 2'b10});
    release dut.state_q;
    @(posedge clk);
    #1 check("unused_to_ga", {5'd0, st}, 8'h00);
    model_reset(1'b1);
    @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      compare("after_force");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tl_cntr.md
TL_CNTR -- requirements
Module: tl_cntr

Interface
REQ-001 The block SHALL expose parameter GREEN_MIN, default 4, minimum green duration in clk cycles.
REQ-002 The block SHALL expose parameter GREEN_MAX, default 8, green duration after which a waiting cross road forces a change.
REQ-003 The block SHALL expose parameter YELLOW_CYC, default 2, exact yellow duration in clk cycles.
REQ-004 The block SHALL expose parameter ALLRED_CYC, default 1, all-red clearance duration in cycles (used only with the REQ-026 macro).
REQ-005 The block SHALL expose port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL expose port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL expose port Ta, input, 1 bit: road A sensor, 1 = traffic present.
REQ-008 The block SHALL expose port Tb, input, 1 bit: road B sensor, 1 = traffic present.
REQ-009 The block SHALL expose port La, output, 2 bits: road A light, encoded 00 green, 01 yellow, 10 red; 11 is never driven.
REQ-010 The block SHALL expose port Lb, output, 2 bits: road B light, same encoding as La.
REQ-011 The block SHALL expose port state, output, 3 bits: current state code, for debug.

Function
REQ-012 The block SHALL be a Moore machine; La, Lb and state SHALL be decoded from the state register only, with no combinational path from Ta or Tb.
REQ-013 The states SHALL be GA (A green, B red), YA (A yellow, B red), GB (A red, B green) and YB (A red, B yellow), with codes 000, 001, 010 and 011.
REQ-014 An 8-bit dwell counter SHALL clear to 0 on every state change, increment each cycle otherwise, and saturate at GREEN_MAX-1.
REQ-015 GA SHALL go to YA at an edge when count >= GREEN_MIN-1 and either Ta=0, or Tb=1 with count = GREEN_MAX-1.
REQ-016 Otherwise, GA SHALL hold; with Tb=0, GA holds indefinitely while Ta=1.
REQ-017 GB SHALL mirror GA with the roles of Ta and Tb swapped and GB -> YB as the exit.
REQ-018 YA SHALL last exactly YELLOW_CYC cycles, then go to GB; YB SHALL last exactly YELLOW_CYC cycles, then go to GA (with the macro absent).
REQ-019 With Ta=0 and Tb=0, the controller SHALL alternate, each green lasting exactly GREEN_MIN cycles.
REQ-020 With Ta=1 and Tb=1, each green SHALL last exactly GREEN_MAX cycles, so neither road starves.
REQ-021 Ta and Tb SHALL be sampled only at rising edges of clk.
REQ-022 Legal parameter ranges SHALL be 1 <= GREEN_MIN <= GREEN_MAX <= 255, YELLOW_CYC >= 1 and ALLRED_CYC >= 1.
REQ-023 Unused state codes SHALL transition to GA on the next edge.

Reset
REQ-024 When reset_n=0, the block SHALL immediately force state GA, count 0, La=00 and Lb=10, independent of clk, including mid-green and mid-yellow.
REQ-025 After reset_n rises, the first edge SHALL count as dwell cycle 0 of GA.

Configuration
REQ-026 When macro TL_ALLRED_EN is defined, states RA (code 100, exiting YA) and RB (code 101, exiting YB) SHALL be compiled in.
REQ-027 With TL_ALLRED_EN defined, RA and RB SHALL each drive La=Lb=10 for exactly ALLRED_CYC cycles, then go to GB and GA respectively.
REQ-028 Without TL_ALLRED_EN, YA SHALL go directly to GB and YB directly to GA, and codes 100 and 101 SHALL be treated as unused per REQ-023.

Verification
REQ-029 Defaults, macro off, Ta=0, Tb=1 after reset: La=00 for cycles 0-3, La=01 for cycles 4-5, and Lb=00 from cycle 6.
REQ-030 Ta=1, Tb=0 held for 50 cycles: the block SHALL stay in GA throughout, with La=00 and Lb=10.
REQ-031 Ta=Tb=1: the green periods of A and B SHALL each measure 8 cycles, separated by 2 yellow cycles.
REQ-032 reset_n pulsed low for 3 ns in the middle of YB: La=00, Lb=10 and state=000 SHALL appear before the next clk edge.
REQ-033 TL_ALLRED_EN defined, Ta=0, Tb=1: cycle 6 SHALL show state=100 with La=Lb=10, and cycle 7 SHALL show Lb=00.
REQ-034 State register forced to 111 through the bench: state SHALL read 000 after one edge.
